// File: rtl/up_down_counter.sv
// Loadable up/down counter with asynchronous active-low reset.
// Moves every clock edge: a load, an increment or a decrement, modulo 2^WIDTH.
module up_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] din,
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             ud,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load wins over direction; there is no hold, so the register always moves.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = din;
    end else if (ud) begin
      count_d = count_q + WIDTH'(1);
    end else begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_up_down_counter.sv
// Directed bench for up_down_counter (WIDTH=4): load, up/down, wrap, async reset.
module tb_up_down_counter;

  localparam int unsigned WIDTH = 4;

  logic [WIDTH-1:0] din;
  logic             clk;
  logic             rst;
  logic             load;
  logic             ud;
  logic [WIDTH-1:0] count;

  int checks = 0;
  int errors = 0;

  up_down_counter #(.WIDTH(WIDTH)) dut (
    .din  (din),
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .ud   (ud),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] exp);
    checks++;
    assert (count === exp) else begin
      errors++;
      $error("FAIL %s: count=%0d expected=%0d", tag, count, exp);
    end
  endtask

  // Advance one rising edge and sample just after it.
  task automatic step(input string tag, input logic [WIDTH-1:0] exp);
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    rst  = 1'b0;
    load = 1'b0;
    ud   = 1'b0;
    din  = '0;
    #2;
    check("reset_state", 4'd0);

    // Reset overrides a load request across a clock edge.
    load = 1'b1;
    din  = 4'd5;
    step("reset_holds_load", 4'd0);

    @(negedge clk);
    rst  = 1'b1;
    load = 1'b1;
    din  = 4'd4;
    step("load4", 4'd4);

    @(negedge clk);
    load = 1'b0;
    ud   = 1'b1;
    step("up5", 4'd5);
    step("up6", 4'd6);
    step("up7", 4'd7);
    step("up8", 4'd8);
    step("up9", 4'd9);

    // Load priority over ud.
    @(negedge clk);
    load = 1'b1;
    ud   = 1'b1;
    din  = 4'd9;
    step("load_prio9", 4'd9);
    @(negedge clk);
    din = 4'd1;
    step("load_prio1", 4'd1);

    // Async reset between edges, mid-count.
    @(negedge clk);
    load = 1'b0;
    ud   = 1'b1;
    rst  = 1'b0;
    #1;
    check("async_clear", 4'd0);
    step("reset_stays0", 4'd0);

    // Down from 0 wraps.
    @(negedge clk);
    rst = 1'b1;
    ud  = 1'b0;
    step("down_wrap15", 4'd15);
    step("down14", 4'd14);

    // Up wrap, with din wiggling while load=0.
    @(negedge clk);
    load = 1'b1;
    din  = 4'd14;
    step("load14", 4'd14);
    @(negedge clk);
    load = 1'b0;
    ud   = 1'b1;
    din  = 4'd3;
    step("up15", 4'd15);
    @(negedge clk);
    din = 4'd8;
    step("up_wrap0", 4'd0);
    @(negedge clk);
    din = 4'd12;
    step("up1", 4'd1);

    // A load pulse that dies before the edge must not be seen.
    @(negedge clk);
    load = 1'b1;
    din  = 4'd10;
    #1;
    load = 1'b0;
    step("glitch_ignored", 4'd2);

    // Async reset during a load cycle, then recovery.
    @(negedge clk);
    load = 1'b1;
    din  = 4'd7;
    #1;
    rst = 1'b0;
    #1;
    check("async_clear_load", 4'd0);
    step("reset_over_load", 4'd0);
    @(negedge clk);
    rst  = 1'b1;
    load = 1'b0;
    ud   = 1'b1;
    step("recover1", 4'd1);
    step("recover2", 4'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/up_down_counter.md
UP_DOWN_COUNTER -- requirements
Module: up_down_counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter and data width in bits; the block SHALL work for any WIDTH >= 2.
REQ-002 Port order SHALL be din, clk, rst, load, ud, count, so that positional instantiation works.
REQ-003 clk  input  1  single clock; all state changes except reset occur on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; rst=0 resets the counter immediately, independent of clk.
REQ-005 din  input  WIDTH  parallel load value, sampled on a rising clk edge when load=1.
REQ-006 load  input  1  synchronous parallel-load request, active-high.
REQ-007 ud  input  1  count direction: 1 = up (increment), 0 = down (decrement).
REQ-008 count  output  WIDTH  current counter value, driven directly from a register with no combinational path from inputs.

Function
REQ-009 The counter SHALL be a single WIDTH-bit register; count SHALL always equal the register contents.
REQ-010 On each rising clk edge with rst=1, the next value SHALL be chosen by this priority: load=1 -> din; else ud=1 -> count+1; else count-1.
REQ-011 The counter SHALL change on every rising edge while rst=1; there is no hold state.
REQ-012 Load SHALL take priority over ud; ud SHALL be ignored in a cycle where load=1.
REQ-013 Arithmetic SHALL be unsigned modulo 2^WIDTH: up from 2^WIDTH-1 wraps to 0; down from 0 wraps to 2^WIDTH-1; no saturation and no flags.
REQ-014 Latency SHALL be one clock: a load or count step is visible on count right after the rising edge that samples it.
REQ-015 din SHALL affect count only on edges where load=1.
REQ-016 Inputs SHALL be sampled only at the rising clk edge; glitches between edges SHALL have no effect.

Reset
REQ-017 While rst=0, count SHALL be 0 regardless of clk, load, ud and din.
REQ-018 Reset assertion SHALL clear count asynchronously, with no clk edge needed, including mid-count or during a load cycle.
REQ-019 After rst returns to 1, the first rising clk edge SHALL apply REQ-010 normally, starting from 0.
REQ-020 Reset SHALL override load and ud unconditionally.

Verification
REQ-021 Async reset: count at a non-zero value, drive rst=0 between clock edges -> count=0 at once, before the next rising edge; stays 0 while rst=0.
REQ-022 Load then count up: rst=1, load=1, din=4 for one edge -> count=4; then load=0, ud=1 for 5 edges -> 5,6,7,8,9.
REQ-023 Load priority: count=9, load=1, ud=1, din=9 -> count=9, not 10; load=1, din=1 -> count=1.
REQ-024 Count down with wrap: rst=1, count=0, load=0, ud=0 for 2 edges -> 15, then 14 (WIDTH=4).
REQ-025 Up wrap: load din=14, then ud=1 for 3 edges -> 15, 0, 1; changes on din while load=0 have no effect.
REQ-026 Reset recovery: rst=0 then rst=1, ud=1 for 2 edges -> 1, 2.
